// File: rtl/pdl_ram_port.sv
// pdl_ram_port: push-down-list buffer RAM and its per-phase port sequencer.
// After reset, a sweep writes zero to every word while pdl_busy is high.
// Reads are addressed in decode and captured into pdl at the end of read.
// Writes are addressed in alu and committed at the end of write.
// Optional feature macro: PDL_PARITY_EN adds an even-parity bit to each
// RAM word and a sticky pdl_parerr output.
//
// Handshake: there is no valid/ready pair. The one-hot phase inputs are the
// only qualifiers. An action takes effect on the clock edge that ends the
// phase that requests it. Core traffic is ignored while pdl_busy is high.
module pdl_ram_port #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              state_decode,
  input  logic              state_read,
  input  logic              state_alu,
  input  logic              state_write,
  input  logic              state_fetch,
  input  logic [ADDR_W-1:0] pdlidx,
  input  logic [ADDR_W-1:0] pdlptr,
  input  logic              srcpdl,
  input  logic              srcpdlidx,
  input  logic              destpdl,
  input  logic              destpdlx,
  input  logic [DATA_W-1:0] l,
  output logic [DATA_W-1:0] pdl,
  output logic              pdldrive,
  output logic              pdl_busy
`ifdef PDL_PARITY_EN
  ,
  output logic              pdl_parerr
`endif
);

`ifdef PDL_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam state_t RESET_ST = (CLEAR_ON_RESET != 0) ? ST_SWEEP : ST_IDLE;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] ra_q, ra_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic              we_pend_q, we_pend_d;
  logic [DATA_W-1:0] pdl_q, pdl_d;

  logic [RAM_W-1:0]  mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [RAM_W-1:0]  mem_wd;
  logic [RAM_W-1:0]  rd_word;

  logic ph_decode, ph_read, ph_alu, ph_write;
  logic core_ok;
  logic rd_en;

  // Phase priority: decode > read > alu > write. Fetch has no sequential action.
  always_comb begin
    ph_decode = state_decode;
    ph_read   = state_read  & ~state_decode;
    ph_alu    = state_alu   & ~state_decode & ~state_read;
    ph_write  = state_write & ~state_decode & ~state_read & ~state_alu;
  end

  assign pdl_busy = (state_q == ST_SWEEP);
  assign core_ok  = ~pdl_busy;
  assign rd_en    = core_ok & ph_read;
  assign rd_word  = mem_q[ra_q];
  assign pdl      = pdl_q;
  assign pdldrive = srcpdl & (state_alu | state_write | state_fetch) & ~pdl_busy;

  // Sweep FSM next state. The counter wraps to 0 on the last write, which ends the sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sweep FSM state and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Core address, strobe and read-data next state.
  always_comb begin
    ra_d      = ra_q;
    wa_d      = wa_q;
    we_pend_d = we_pend_q;
    pdl_d     = pdl_q;
    if (core_ok && ph_decode && srcpdl) begin
      ra_d = srcpdlidx ? pdlidx : pdlptr;
    end
    if (rd_en) begin
      pdl_d = rd_word[DATA_W-1:0];
    end
    if (core_ok && ph_alu) begin
      // The pointer seen here is already post-increment for a push.
      if (destpdl) begin
        wa_d = destpdlx ? pdlidx : pdlptr;
      end
      we_pend_d = destpdl;
    end
    if (core_ok && ph_write && we_pend_q) begin
      we_pend_d = 1'b0;
    end
  end

  // Core address, strobe and read-data registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ra_q      <= '0;
      wa_q      <= '0;
      we_pend_q <= 1'b0;
      pdl_q     <= '0;
    end else begin
      ra_q      <= ra_d;
      wa_q      <= wa_d;
      we_pend_q <= we_pend_d;
      pdl_q     <= pdl_d;
    end
  end

  // Single RAM write port, shared between the zero sweep and core writes.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (pdl_busy) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
    end else if (ph_write && we_pend_q) begin
      mem_we = 1'b1;
      mem_wa = wa_q;
`ifdef PDL_PARITY_EN
      mem_wd = {^l, l};
`else
      mem_wd = l;
`endif
    end
  end

  // RAM array write. The array itself has no reset; the sweep clears it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

`ifdef PDL_PARITY_EN
  logic parerr_q, parerr_d;

  // A captured word whose bits (data plus stored parity) do not XOR to zero sets the sticky error.
  always_comb begin
    parerr_d = parerr_q;
    if (rd_en && (^rd_word)) begin
      parerr_d = 1'b1;
    end
  end

  // Sticky parity error register. Only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parerr_q <= 1'b0;
    end else begin
      parerr_q <= parerr_d;
    end
  end

  assign pdl_parerr = parerr_q;
`endif

endmodule

// File: tb/tb_pdl_ram_port.sv
// tb_pdl_ram_port: directed test of pdl_ram_port, covering the reset sweep,
// push/pop and index traffic, same-instruction read/write and reset during a sweep.
module tb_pdl_ram_port;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        state_decode = 1'b0;
  logic        state_read = 1'b0;
  logic        state_alu = 1'b0;
  logic        state_write = 1'b0;
  logic        state_fetch = 1'b0;
  logic [9:0]  pdlidx = '0;
  logic [9:0]  pdlptr = '0;
  logic        srcpdl = 1'b0;
  logic        srcpdlidx = 1'b0;
  logic        destpdl = 1'b0;
  logic        destpdlx = 1'b0;
  logic [31:0] l = '0;
  logic [31:0] pdl;
  logic        pdldrive;
  logic        pdl_busy;
`ifdef PDL_PARITY_EN
  logic        pdl_parerr;
`endif

  int errors = 0;
  int checks = 0;

  // Values observed during the last instruction.
  logic [31:0] obs_pdl_alu, obs_pdl_wr, obs_pdl_fetch, obs_pdl_after;
  logic        obs_drv_dec, obs_drv_alu, obs_drv_wr, obs_drv_fetch;

  pdl_ram_port #(
    .ADDR_W(10),
    .DATA_W(32),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .state_decode(state_decode),
    .state_read(state_read),
    .state_alu(state_alu),
    .state_write(state_write),
    .state_fetch(state_fetch),
    .pdlidx(pdlidx),
    .pdlptr(pdlptr),
    .srcpdl(srcpdl),
    .srcpdlidx(srcpdlidx),
    .destpdl(destpdl),
    .destpdlx(destpdlx),
    .l(l),
    .pdl(pdl),
    .pdldrive(pdldrive),
    .pdl_busy(pdl_busy)
`ifdef PDL_PARITY_EN
    ,
    .pdl_parerr(pdl_parerr)
`endif
  );

  // Clock generation: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_phase(input logic [4:0] ph);
    {state_decode, state_read, state_alu, state_write, state_fetch} = ph;
  endtask

  // One full instruction: decode, read, alu, write, fetch, one cycle each.
  task automatic instr(input logic src, input logic sidx, input logic dst, input logic dx,
                       input logic [9:0] idx, input logic [9:0] ptr, input logic [31:0] ldat);
    srcpdl = src; srcpdlidx = sidx; destpdl = dst; destpdlx = dx;
    pdlidx = idx; pdlptr = ptr; l = ldat;
    set_phase(5'b10000); #1; obs_drv_dec = pdldrive; tick();
    set_phase(5'b01000); tick();
    set_phase(5'b00100); #1; obs_pdl_alu = pdl; obs_drv_alu = pdldrive; tick();
    set_phase(5'b00010); #1; obs_pdl_wr = pdl; obs_drv_wr = pdldrive; tick();
    set_phase(5'b00001); #1; obs_pdl_fetch = pdl; obs_drv_fetch = pdldrive; tick();
    set_phase(5'b00000);
    srcpdl = 1'b0; destpdl = 1'b0;
    obs_pdl_after = pdl;
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_pdl", pdl, 32'h0);
    check("rst_pdldrive", {31'b0, pdldrive}, 32'h0);
    check("rst_busy", {31'b0, pdl_busy}, 32'h1);
    reset = 1'b0;

    // Full sweep takes exactly 1024 cycles.
    n = 0;
    while (pdl_busy && n < 2000) begin
      tick();
      n++;
    end
    check("sweep_len", n, 1024);

    // Read of the last word after the sweep returns zero.
    instr(1'b1, 1'b1, 1'b0, 1'b0, 10'h3FF, 10'h000, 32'h0);
    check("rd_3ff", obs_pdl_alu, 32'h0);

    // Push 0xDEADBEEF to pointer 5, then pop it.
    instr(1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h005, 32'hDEADBEEF);
    check("wr_only_drv", {31'b0, obs_drv_alu}, 32'h0);
    instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h005, 32'h0);
    check("pop_dec_drv", {31'b0, obs_drv_dec}, 32'h0);
    check("pop_alu_pdl", obs_pdl_alu, 32'hDEADBEEF);
    check("pop_wr_pdl", obs_pdl_wr, 32'hDEADBEEF);
    check("pop_fetch_pdl", obs_pdl_fetch, 32'hDEADBEEF);
    check("pop_alu_drv", {31'b0, obs_drv_alu}, 32'h1);
    check("pop_wr_drv", {31'b0, obs_drv_wr}, 32'h1);
    check("pop_fetch_drv", {31'b0, obs_drv_fetch}, 32'h1);
    check("pop_hold", obs_pdl_after, 32'hDEADBEEF);

    // Index write then index read; pointer read at 0 is untouched.
    instr(1'b0, 1'b0, 1'b1, 1'b1, 10'h1A0, 10'h000, 32'h12345678);
    instr(1'b1, 1'b1, 1'b0, 1'b0, 10'h1A0, 10'h000, 32'h0);
    check("idx_rd_1a0", obs_pdl_alu, 32'h12345678);
    instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h1A0, 10'h000, 32'h0);
    check("ptr_rd_000", obs_pdl_alu, 32'h0);

    // Same-instruction read and write of address 7: old value now, new value next.
    instr(1'b0, 1'b0, 1'b1, 1'b0, 10'h000, 10'h007, 32'h1);
    instr(1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 10'h007, 32'h2);
    check("rw7_old", obs_pdl_alu, 32'h1);
    instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h007, 32'h0);
    check("rw7_new", obs_pdl_alu, 32'h2);

    // Reset pulsed 300 cycles into a sweep restarts it from zero.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (300) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_pdl", pdl, 32'h0);
    tick();
    reset = 1'b0;
    n = 0;
    repeat (100) begin
      tick();
      n++;
    end
    // Core write to an already-swept address must not land; read must not drive.
    instr(1'b1, 1'b0, 1'b1, 1'b0, 10'h000, 10'h005, 32'hAAAA5555);
    n += 5;
    check("sweep_drv", {31'b0, obs_drv_alu}, 32'h0);
    check("sweep_pdl", obs_pdl_fetch, 32'h0);
    check("sweep_busy_mid", {31'b0, pdl_busy}, 32'h1);
    while (pdl_busy && n < 2000) begin
      tick();
      n++;
    end
    check("sweep2_len", n, 1024);
    instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h005, 32'h0);
    check("sweep_wr_blocked", obs_pdl_alu, 32'h0);
    instr(1'b1, 1'b1, 1'b0, 1'b0, 10'h1A0, 10'h000, 32'h0);
    check("sweep_cleared_1a0", obs_pdl_alu, 32'h0);

`ifdef PDL_PARITY_EN
    // Good word reads clean; a flipped data bit raises a sticky error.
    instr(1'b0, 1'b0, 1'b1, 1'b1, 10'h003, 10'h000, 32'h00000007);
    instr(1'b1, 1'b1, 1'b0, 1'b0, 10'h003, 10'h000, 32'h0);
    check("par_clean", {31'b0, pdl_parerr}, 32'h0);
    dut.mem_q[3] = dut.mem_q[3] ^ 33'h1;
    instr(1'b1, 1'b1, 1'b0, 1'b0, 10'h003, 10'h000, 32'h0);
    check("par_err", {31'b0, pdl_parerr}, 32'h1);
    instr(1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 32'h0);
    check("par_sticky", {31'b0, pdl_parerr}, 32'h1);
    reset = 1'b1;
    #1;
    check("par_rst", {31'b0, pdl_parerr}, 32'h0);
    tick();
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time bound so the run always ends.
  initial begin
    #500000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
